// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and the datapath (slave).
interface mc_ctrl_fsm_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               pcen;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [1:0]         aluop;
    logic               illegal_op;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        input  op, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, dbg_state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, dbg_state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: sequences ALU, register file, IR/PC and unified memory,
// with optional wait states on mem_ready.
//
// state      | meaning
// FETCH  0   | read instr at PC, PC+4 (waits for memory)
// DECODE 1   | read regs, compute branch target, dispatch on op
// MEMADR 2   | compute lw/sw address
// MEMRD  3   | read data memory (waits for memory)
// MEMWB  4   | write MDR to rt
// MEMWR  5   | write data memory (waits for memory)
// EXEC   6   | R-type ALU op
// ALUWB  7   | write ALUOut to rd
// BEQ    8   | compare, branch if zero
// ADDIEX 9   | rs + signimm
// ADDIWB 10  | write ALUOut to rt
// JUMP   11  | load jump target
module mc_ctrl_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXEC   = STATE_W'(6),
        S_ALUWB  = STATE_W'(7),
        S_BEQ    = STATE_W'(8),
        S_ADDIEX = STATE_W'(9),
        S_ADDIWB = STATE_W'(10),
        S_JUMP   = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    logic       ready;
    logic       pcwrite, branch, illegal;
    logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;

    assign ready = bus.mem_ready || !MEM_HANDSHAKE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                // PC only advances together with the IR load
                if (ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Write strobes are gated by rst_n so an in-flight access dies the moment reset asserts
    assign bus.pcen       = rst_n & (pcwrite | (branch & bus.zero));
    assign bus.memwrite   = rst_n & memwrite;
    assign bus.irwrite    = rst_n & irwrite;
    assign bus.regwrite   = rst_n & regwrite;
    assign bus.illegal_op = rst_n & illegal;
    assign bus.iord       = iord;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.aluop      = aluop;
    assign bus.dbg_state  = state_q;
endmodule
